// File: rtl/ws2812_rx_decoder.sv
`timescale 1ns/1ps
// WS2812B line decoder: classifies high pulses, packs MSB-first GRB words, detects frame reset gaps.
// Words appear 3 clk after the sampled falling edge of their 24th bit; no backpressure, pulses only.
module ws2812_rx_decoder #(
    parameter int ONE_THRESH   = 60,
    parameter int MIN_HIGH     = 15,
    parameter int MAX_HIGH     = 120,
    parameter int RESET_CYCLES = 28000,
    parameter int CNT_W        = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dataIn,
    input  logic        clr_err,
    output logic [23:0] grb,
    output logic        grb_valid,
    output logic [11:0] led_index,
    output logic        frame_done,
    output logic [11:0] led_total,
    output logic        bit_err,
    output logic        idle
);

    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(ONE_THRESH);
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] RESET_C = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {WAIT_RESET, IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic             dinM, dinS, dinD;
    logic             rise, fall;
    logic [CNT_W-1:0] hcnt, lcnt;
    logic [4:0]       bitCnt;
    logic [23:0]      sreg;
    logic [11:0]      index;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dinM <= 1'b0;
            dinS <= 1'b0;
            dinD <= 1'b0;
        end else begin
            dinM <= dataIn;
            dinS <= dinM;
            dinD <= dinS;
        end
    end

    assign rise = dinS & ~dinD;
    assign fall = ~dinS & dinD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= WAIT_RESET;
            hcnt       <= '0;
            lcnt       <= '0;
            bitCnt     <= '0;
            sreg       <= '0;
            index      <= '0;
            grb        <= '0;
            grb_valid  <= 1'b0;
            led_index  <= '0;
            frame_done <= 1'b0;
            led_total  <= '0;
            bit_err    <= 1'b0;
            idle       <= 1'b0;
        end else begin
            grb_valid  <= 1'b0;
            frame_done <= 1'b0;
            // Later error assignments override the clear, so a same-cycle error wins.
            if (clr_err)
                bit_err <= 1'b0;

            // The 24th bit was shifted in on the previous cycle; publish the word now.
            if (state == LOW && bitCnt == 5'd24) begin
                grb       <= sreg;
                led_index <= index;
                grb_valid <= 1'b1;
                bitCnt    <= '0;
                if (index == 12'hFFF)
                    bit_err <= 1'b1;
                else
                    index <= index + 12'd1;
            end

            case (state)
                WAIT_RESET: begin
                    if (dinS) begin
                        lcnt <= '0;
                    end else if (lcnt >= RESET_C) begin
                        state  <= IDLE;
                        idle   <= 1'b1;
                        lcnt   <= '0;
                        bitCnt <= '0;
                        index  <= '0;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        hcnt  <= CNT_W'(1);
                        state <= HIGH;
                        idle  <= 1'b0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        lcnt  <= CNT_W'(1);
                        state <= LOW;
                        if (hcnt < MIN_C) begin
                            bit_err <= 1'b1;
                            bitCnt  <= '0;
                        end else begin
                            sreg   <= {sreg[22:0], hcnt >= ONE_C};
                            bitCnt <= bitCnt + 5'd1;
                        end
                    end else if (hcnt >= MAX_C) begin
                        // Line stuck high: abandon the frame and resynchronise on a full gap.
                        bit_err <= 1'b1;
                        bitCnt  <= '0;
                        lcnt    <= '0;
                        state   <= WAIT_RESET;
                    end else if (hcnt != CNT_MAX) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        hcnt  <= CNT_W'(1);
                        state <= HIGH;
                    end else if (lcnt >= RESET_C) begin
                        if (bitCnt != 5'd0)
                            bit_err <= 1'b1;
                        if (index != 12'd0) begin
                            led_total  <= index;
                            frame_done <= 1'b1;
                        end
                        index  <= '0;
                        bitCnt <= '0;
                        state  <= IDLE;
                        idle   <= 1'b1;
                    end else if (lcnt != CNT_MAX) begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                default: state <= WAIT_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
`timescale 1ns/1ps
// Bench for ws2812_rx_decoder: scoreboarded words/frames plus a table-driven pulse-width sweep.
module tb_ws2812_rx_decoder;

    localparam int RST_CYC = 1000;
    localparam int GAP     = 1100;

    logic        clk = 1'b0;
    logic        reset;
    logic        dataIn;
    logic        clrErr;
    logic [23:0] grb;
    logic        grbValid;
    logic [11:0] ledIndex;
    logic        frameDone;
    logic [11:0] ledTotal;
    logic        bitErr;
    logic        idle;

    always #5 clk = ~clk;

    ws2812_rx_decoder #(.RESET_CYCLES(RST_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .dataIn     (dataIn),
        .clr_err    (clrErr),
        .grb        (grb),
        .grb_valid  (grbValid),
        .led_index  (ledIndex),
        .frame_done (frameDone),
        .led_total  (ledTotal),
        .bit_err    (bitErr),
        .idle       (idle)
    );

    typedef struct {
        logic [23:0] grb;
        logic [11:0] idx;
    } exp_t;

    typedef struct {
        int   hi;
        logic b;
        logic err;
    } vec_t;

    exp_t expQ[$];
    int   frmQ[$];
    exp_t monE;
    int   monT;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sendHigh(input int hi, input int lo);
        dataIn = 1'b1;
        repeat (hi) @(negedge clk);
        dataIn = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic sendBit(input logic b);
        if (b) sendHigh(80, 45);
        else   sendHigh(40, 85);
    endtask

    task automatic sendWord(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) sendBit(w[i]);
    endtask

    task automatic gap();
        dataIn = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic expWord(input logic [23:0] w, input int idx);
        exp_t e;
        e.grb = w;
        e.idx = 12'(idx);
        expQ.push_back(e);
    endtask

    task automatic pulseClr();
        clrErr = 1'b1;
        @(negedge clk);
        clrErr = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (grbValid) begin
            if (expQ.size() == 0) begin
                chk("grb_valid_unexpected", 32'(grbValid), 32'd0);
            end else begin
                monE = expQ.pop_front();
                chk("grb", 32'(grb), 32'(monE.grb));
                chk("led_index", 32'(ledIndex), 32'(monE.idx));
            end
        end
        if (frameDone) begin
            if (frmQ.size() == 0) begin
                chk("frame_done_unexpected", 32'(frameDone), 32'd0);
            end else begin
                monT = frmQ.pop_front();
                chk("led_total", 32'(ledTotal), 32'(monT));
            end
        end
    end

    initial begin
        vec_t        vt[6];
        logic [23:0] w;
        logic [23:0] base;
        int          tbIdx;

        vt[0] = '{59, 1'b0, 1'b0};
        vt[1] = '{60, 1'b1, 1'b0};
        vt[2] = '{14, 1'b0, 1'b1};
        vt[3] = '{15, 1'b0, 1'b0};
        vt[4] = '{120, 1'b1, 1'b0};
        vt[5] = '{16, 1'b0, 1'b0};
        base  = 24'hC3A55A;

        reset  = 1'b0;
        dataIn = 1'b0;
        clrErr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grb", 32'(grb), 32'd0);
        chk("rst_grb_valid", 32'(grbValid), 32'd0);
        chk("rst_led_index", 32'(ledIndex), 32'd0);
        chk("rst_frame_done", 32'(frameDone), 32'd0);
        chk("rst_led_total", 32'(ledTotal), 32'd0);
        chk("rst_bit_err", 32'(bitErr), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);

        reset = 1'b1;
        gap();
        chk("idle_after_gap", 32'(idle), 32'd1);

        // Single LED, with exact output latency on the last bit.
        w = 24'h00FF00;
        expWord(w, 0);
        frmQ.push_back(1);
        for (int i = 23; i >= 1; i--) sendBit(w[i]);
        dataIn = 1'b1;
        repeat (40) @(negedge clk);
        dataIn = 1'b0;
        repeat (3) @(negedge clk);
        chk("latency_early", 32'(grbValid), 32'd0);
        @(negedge clk);
        chk("latency_exact", 32'(grbValid), 32'd1);
        gap();
        chk("t1_bit_err", 32'(bitErr), 32'd0);
        chk("t1_pending", 32'(expQ.size() + frmQ.size()), 32'd0);

        // Three back-to-back LEDs.
        expWord(24'h123456, 0);
        expWord(24'hABCDEF, 1);
        expWord(24'h000001, 2);
        frmQ.push_back(3);
        sendWord(24'h123456);
        sendWord(24'hABCDEF);
        sendWord(24'h000001);
        gap();
        chk("t2_pending", 32'(expQ.size() + frmQ.size()), 32'd0);

        // Pulse-width sweep on the 24th bit of each word.
        tbIdx = 0;
        for (int v = 0; v < 6; v++) begin
            pulseClr();
            chk("sweep_clr", 32'(bitErr), 32'd0);
            if (!vt[v].err) begin
                expWord({base[23:1], vt[v].b}, tbIdx);
                tbIdx++;
            end
            for (int i = 23; i >= 1; i--) sendBit(base[i]);
            sendHigh(vt[v].hi, 60);
            chk($sformatf("sweep_err_hi%0d", vt[v].hi), 32'(bitErr), 32'(vt[v].err));
        end
        frmQ.push_back(tbIdx);
        gap();
        chk("sweep_pending", 32'(expQ.size() + frmQ.size()), 32'd0);

        // Over-long high drops back to waiting for a gap; the next word is ignored.
        pulseClr();
        sendHigh(121, 10);
        chk("long_high_err", 32'(bitErr), 32'd1);
        sendWord(24'h0F0F0F);
        gap();
        chk("long_high_resync", 32'(idle), 32'd1);

        // Partial word before a reset gap.
        pulseClr();
        for (int i = 23; i >= 14; i--) sendBit(base[i]);
        gap();
        chk("partial_err", 32'(bitErr), 32'd1);
        pulseClr();
        chk("partial_clr", 32'(bitErr), 32'd0);

        // Traffic straight after reset release is ignored until a full gap.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sendWord(24'h5A5A5A);
        gap();
        chk("startup_idle", 32'(idle), 32'd1);
        expWord(24'h3C0FF0, 0);
        frmQ.push_back(1);
        sendWord(24'h3C0FF0);
        gap();

        // Reset asserted during the 12th bit.
        w = 24'h3C0FF0;
        for (int i = 23; i >= 13; i--) sendBit(w[i]);
        dataIn = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_grb", 32'(grb), 32'd0);
        chk("midrst_led_total", 32'(ledTotal), 32'd0);
        chk("midrst_led_index", 32'(ledIndex), 32'd0);
        chk("midrst_idle", 32'(idle), 32'd0);
        chk("midrst_bit_err", 32'(bitErr), 32'd0);
        dataIn = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        gap();
        chk("midrst_resync", 32'(idle), 32'd1);
        expWord(24'h81C3E7, 0);
        frmQ.push_back(1);
        sendWord(24'h81C3E7);
        gap();
        chk("final_bit_err", 32'(bitErr), 32'd0);

        chk("expq_empty", 32'(expQ.size()), 32'd0);
        chk("frmq_empty", 32'(frmQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
